// File: rtl/scan_sequencer_if.sv
// Scan sequencer control/select bundle: scan command inputs plus decoder drive outputs.
// Latency: none, pure wiring between controller and sequencer.
// Backpressure: none; start is a level sampled in IDLE, stop aborts at any time.
interface scan_sequencer_if #(
    parameter int DWELL_W = 8
);
    logic               start;
    logic               stop;
    logic               mode;
    logic [DWELL_W-1:0] dwell;
    logic [15:0]        chan_mask;
    logic [3:0]         sel;
    logic               sel_en;
    logic               busy;
    logic               done;
    logic               wrap;

    // Controller side: issues scan commands, observes decoder drive.
    modport master (
        output start, stop, mode, dwell, chan_mask,
        input  sel, sel_en, busy, done, wrap
    );

    // Sequencer side.
    modport slave (
        input  start, stop, mode, dwell, chan_mask,
        output sel, sel_en, busy, done, wrap
    );
endinterface

// File: rtl/scan_sequencer.sv
// Timed channel scanner driving a 4-to-16 decoder select/enable; optional SCAN_SEQ_BLANK_EN inserts a blank cycle between channels.
// Latency: first channel driven one cycle after start; each channel held max(dwell,1) cycles.
// Backpressure: none; start ignored while busy, stop aborts on the next edge without done/wrap.
module scan_sequencer #(
    parameter int DWELL_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    scan_sequencer_if.slave bus
);

`ifdef SCAN_SEQ_BLANK_EN
    typedef enum logic [1:0] {IDLE, DWELL, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, DWELL} state_t;
`endif

    state_t             state;
    logic [15:0]        mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic               mode_q;
    logic [DWELL_W-1:0] cnt;
    logic [3:0]         sel_q;
    logic               sel_en_q;
    logic               busy_q;
    logic               done_q;
    logic               wrap_q;

    logic [DWELL_W-1:0] dwell_eff;
    logic [15:0]        above_mask;
    logic               next_found;
    logic [3:0]         next_idx;
    logic [3:0]         first_idx;
    logic [3:0]         start_idx;

    // Lowest set bit index; caller checks the mask is non-zero separately.
    function automatic logic [3:0] lowest_idx(input logic [15:0] m);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (m[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Channel search: next enabled channel strictly above the current one, and the wrap target.
    always_comb begin
        dwell_eff  = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;
        above_mask = mask_q & (16'hFFFE << sel_q);
        next_found = |above_mask;
        next_idx   = lowest_idx(above_mask);
        first_idx  = lowest_idx(mask_q);
        start_idx  = lowest_idx(bus.chan_mask);
    end

    // Scan FSM with registered outputs; done/wrap default low so they are single-cycle pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            mask_q   <= '0;
            dwell_q  <= '0;
            mode_q   <= 1'b0;
            cnt      <= '0;
            sel_q    <= 4'd0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            wrap_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.stop) begin
                        mode_q  <= bus.mode;
                        dwell_q <= dwell_eff;
                        mask_q  <= bus.chan_mask;
                        if (bus.chan_mask == 16'h0000) begin
                            done_q <= 1'b1;
                        end else begin
                            sel_q    <= start_idx;
                            sel_en_q <= 1'b1;
                            busy_q   <= 1'b1;
                            cnt      <= dwell_eff;
                            state    <= DWELL;
                        end
                    end
                end
                DWELL: begin
                    if (bus.stop) begin
                        sel_en_q <= 1'b0;
                        busy_q   <= 1'b0;
                        state    <= IDLE;
                    end else if (cnt == DWELL_W'(1)) begin
                        if (next_found) begin
                            sel_q <= next_idx;
                            cnt   <= dwell_q;
`ifdef SCAN_SEQ_BLANK_EN
                            sel_en_q <= 1'b0;
                            state    <= BLANK;
`endif
                        end else if (!mode_q) begin
                            // End of single pass: sel keeps the last channel.
                            done_q   <= 1'b1;
                            sel_en_q <= 1'b0;
                            busy_q   <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            sel_q  <= first_idx;
                            cnt    <= dwell_q;
                            wrap_q <= 1'b1;
`ifdef SCAN_SEQ_BLANK_EN
                            sel_en_q <= 1'b0;
                            state    <= BLANK;
`endif
                        end
                    end else begin
                        cnt <= cnt - DWELL_W'(1);
                    end
                end
`ifdef SCAN_SEQ_BLANK_EN
                BLANK: begin
                    // sel already shows the next channel; counter was loaded on entry.
                    if (bus.stop) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        sel_en_q <= 1'b1;
                        state    <= DWELL;
                    end
                end
`endif
                default: begin
                    sel_en_q <= 1'b0;
                    busy_q   <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

    assign bus.sel    = sel_q;
    assign bus.sel_en = sel_en_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.wrap   = wrap_q;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer (default build): vector table plus hand sequences.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: every wait on the DUT is bounded by a cycle budget.
module tb_scan_sequencer;

    localparam int DWELL_W = 8;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    scan_sequencer_if #(.DWELL_W(DWELL_W)) bus ();

    scan_sequencer #(.DWELL_W(DWELL_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        start;
        logic        stop;
        logic        mode;
        logic [7:0]  dwell;
        logic [15:0] mask;
        logic [3:0]  sel;
        logic        sel_en;
        logic        busy;
        logic        done;
        logic        wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic st, input logic sp, input logic md,
                       input logic [7:0] dw, input logic [15:0] mk,
                       input logic [3:0] s, input logic en, input logic b,
                       input logic d, input logic w);
        vec_t v;
        v.rst = r; v.start = st; v.stop = sp; v.mode = md; v.dwell = dw; v.mask = mk;
        v.sel = s; v.sel_en = en; v.busy = b; v.done = d; v.wrap = w;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic st, input logic sp, input logic md,
                         input logic [7:0] dw, input logic [15:0] mk);
        rst = r; bus.start = st; bus.stop = sp; bus.mode = md; bus.dwell = dw; bus.chan_mask = mk;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.sel, bus.sel_en, bus.busy, bus.done, bus.wrap};
    endfunction

    initial begin
        int n;
        logic seen_done;
        logic gap;
        total = 0;
        bad   = 0;

        // Single pass over channels 0,2,8 with dwell 3.
        add(0,1,0,0,3,16'h0105, 0,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 0,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 0,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 2,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 2,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 2,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 8,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 8,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 8,1,1,0,0);
        add(0,0,0,0,3,16'h0105, 8,0,0,1,0);
        add(0,0,0,0,3,16'h0105, 8,0,0,0,0);
        // Empty mask: done only, sel holds.
        add(0,1,0,0,3,16'h0000, 8,0,0,1,0);
        add(0,0,0,0,3,16'h0000, 8,0,0,0,0);
        // start and stop together in IDLE: stop wins.
        add(0,1,1,0,3,16'h0105, 8,0,0,0,0);
        add(0,0,0,0,3,16'h0105, 8,0,0,0,0);
        // Continuous 0/15 with dwell 0 (treated as 1), then stop.
        add(0,1,0,1,0,16'h8001, 0,1,1,0,0);
        add(0,0,0,1,0,16'h8001, 15,1,1,0,0);
        add(0,0,0,1,0,16'h8001, 0,1,1,0,1);
        add(0,0,0,1,0,16'h8001, 15,1,1,0,0);
        add(0,0,0,1,0,16'h8001, 0,1,1,0,1);
        add(0,0,1,1,0,16'h8001, 0,0,0,0,0);
        add(0,0,0,1,0,16'h8001, 0,0,0,0,0);
        // Continuous 1,2 dwell 2; mid-scan start and new inputs ignored; then reset.
        add(0,1,0,1,2,16'h0006, 1,1,1,0,0);
        add(0,0,0,1,2,16'h0006, 1,1,1,0,0);
        add(0,1,0,0,5,16'hFFFF, 2,1,1,0,0);
        add(0,0,0,0,5,16'hFFFF, 2,1,1,0,0);
        add(0,0,0,0,5,16'hFFFF, 1,1,1,0,1);
        add(0,0,0,0,5,16'hFFFF, 1,1,1,0,0);
        add(0,0,0,0,5,16'hFFFF, 2,1,1,0,0);
        add(1,0,0,0,5,16'hFFFF, 0,0,0,0,0);
        add(0,0,0,0,5,16'hFFFF, 0,0,0,0,0);

        // Reset, then 5 idle cycles at reset values.
        drive(1,0,0,0,8'd0,16'h0000);
        tick();
        tick();
        drive(0,0,0,0,8'd0,16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("idle_%0d", i), 32'(outs()), 32'h0);
        end

        // Vector table.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].mode, vecs[i].dwell, vecs[i].mask);
            tick();
            check($sformatf("vec_%0d", i), 32'(outs()),
                  32'({vecs[i].sel, vecs[i].sel_en, vecs[i].busy, vecs[i].done, vecs[i].wrap}));
        end

        // Single enabled channel in continuous mode: re-dwell with wrap each pass.
        drive(0,1,0,1,8'd2,16'h0010);
        tick();
        check("single_c1", 32'(outs()), 32'({4'd4, 1'b1, 1'b1, 1'b0, 1'b0}));
        drive(0,0,0,0,8'd9,16'h0000);
        tick();
        check("single_c2", 32'(outs()), 32'({4'd4, 1'b1, 1'b1, 1'b0, 1'b0}));
        tick();
        check("single_c3_wrap", 32'(outs()), 32'({4'd4, 1'b1, 1'b1, 1'b0, 1'b1}));
        tick();
        check("single_c4", 32'(outs()), 32'({4'd4, 1'b1, 1'b1, 1'b0, 1'b0}));
        tick();
        check("single_c5_wrap", 32'(outs()), 32'({4'd4, 1'b1, 1'b1, 1'b0, 1'b1}));
        bus.stop = 1'b1;
        tick();
        check("single_stop", 32'(outs()), 32'({4'd4, 1'b0, 1'b0, 1'b0, 1'b0}));
        bus.stop = 1'b0;

        // Maximum dwell on channel 0: busy for exactly 255 cycles, sel_en unbroken, then done.
        drive(0,1,0,0,8'd255,16'h0001);
        tick();
        drive(0,0,0,0,8'd255,16'h0001);
        n = 0;
        gap = 1'b0;
        while (bus.busy && n < 400) begin
            if (!bus.sel_en) gap = 1'b1;
            n++;
            tick();
        end
        seen_done = bus.done;
        check("maxdwell_busy_cycles", 32'(n), 32'd255);
        check("maxdwell_sel_en_gap", 32'(gap), 32'd0);
        check("maxdwell_done", 32'(seen_done), 32'd1);
        tick();
        check("maxdwell_after", 32'(outs()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
